// File: rtl/pwr_seq_ctrl_pkg.sv
// Shared definitions for the power sequencer: state codes, state width and
// default sequencing parameters.
package pwr_seq_ctrl_pkg;

  localparam int STATE_W        = 3;
  localparam int DEF_RAIL_NUM   = 4;
  localparam int DEF_PG_TIMEOUT = 255;
  localparam int DEF_STEP_DLY   = 15;
  localparam int DEF_RST_DLY    = 63;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RAIL_ON   = 3'd1,
    ST_WAIT_PG   = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_RST_DLY   = 3'd4,
    ST_RUN       = 3'd5,
    ST_RAIL_OFF  = 3'd6,
    ST_FAULT     = 3'd7
  } seq_state_e;

  function automatic logic [7:0] timer_next(input logic [7:0] t);
    return (t == 8'hFF) ? t : t + 8'd1;
  endfunction

endpackage

// File: rtl/pwr_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous per-rail power-good pins
// into the sequencer clock domain.
module pwr_seq_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power rail sequencer: enables rails in ascending order gated by power-good,
// releases platform reset after a delay, and unwinds rails in reverse on off.
module pwr_seq_ctrl
  import pwr_seq_ctrl_pkg::*;
#(
  parameter int RAIL_NUM   = DEF_RAIL_NUM,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT,
  parameter int STEP_DLY   = DEF_STEP_DLY,
  parameter int RST_DLY    = DEF_RST_DLY
) (
  input  logic                i_InitialSoc,
  input  logic                i_SbyReset_n,
  input  logic                i_PwrOnReq,
  input  logic [RAIL_NUM-1:0] i_RailPG,
  output logic [RAIL_NUM-1:0] o_RailEn,
  output logic                o_PltRst_n,
  output logic                o_PwrFault,
  output logic [STATE_W-1:0]  o_SeqState
);

  localparam int IDX_W = (RAIL_NUM > 1) ? $clog2(RAIL_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAIL_NUM - 1);
  localparam logic [7:0] PG_TO_T = 8'(PG_TIMEOUT);
  localparam logic [7:0] STEP_T  = 8'(STEP_DLY);
  localparam logic [7:0] RST_T   = 8'(RST_DLY);

  seq_state_e          state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_dec;
  logic [RAIL_NUM-1:0] rail_en_q, rail_en_d;
  logic                plt_rst_n_q, plt_rst_n_d;
  logic                pwr_fault_q, pwr_fault_d;
  logic                step_restart;
  logic [RAIL_NUM-1:0] pg;
  logic [RAIL_NUM-1:0] confirmed;
  logic                confirmed_lost;
  logic                enabled_lost;

  pwr_seq_sync #(
    .WIDTH(RAIL_NUM)
  ) u_pg_sync (
    .clk  (i_InitialSoc),
    .rst_n(i_SbyReset_n),
    .d    (i_RailPG),
    .q    (pg)
  );

  // Rails already proven good while the sequence is still climbing.
  always_comb begin
    confirmed = '0;
    for (int i = 0; i < RAIL_NUM; i++) begin
      if (state_q == ST_WAIT_PG) begin
        confirmed[i] = (i < int'(idx_q));
      end else if (state_q == ST_STEP_WAIT) begin
        confirmed[i] = (i <= int'(idx_q));
      end
    end
  end

  assign confirmed_lost = |(confirmed & rail_en_q & ~pg);
  assign enabled_lost   = |(rail_en_q & ~pg);
  assign idx_dec        = idx_q - 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    plt_rst_n_d  = plt_rst_n_q;
    pwr_fault_d  = pwr_fault_q;
    step_restart = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rail_en_d   = '0;
        plt_rst_n_d = 1'b0;
        idx_d       = '0;
        if (i_PwrOnReq) state_d = ST_RAIL_ON;
      end

      ST_RAIL_ON: begin
        rail_en_d[idx_q] = 1'b1;
        state_d          = ST_WAIT_PG;
      end

      ST_WAIT_PG: begin
        if (confirmed_lost || timer_q == PG_TO_T) begin
          state_d     = ST_FAULT;
          rail_en_d   = '0;
          plt_rst_n_d = 1'b0;
          pwr_fault_d = 1'b1;
        end else if (!i_PwrOnReq) begin
          state_d          = ST_RAIL_OFF;
          rail_en_d[idx_q] = 1'b0;
          plt_rst_n_d      = 1'b0;
        end else if (pg[idx_q]) begin
          state_d = (idx_q == LAST_IDX) ? ST_RST_DLY : ST_STEP_WAIT;
        end
      end

      ST_STEP_WAIT: begin
        if (confirmed_lost) begin
          state_d     = ST_FAULT;
          rail_en_d   = '0;
          plt_rst_n_d = 1'b0;
          pwr_fault_d = 1'b1;
        end else if (!i_PwrOnReq) begin
          state_d          = ST_RAIL_OFF;
          rail_en_d[idx_q] = 1'b0;
          plt_rst_n_d      = 1'b0;
        end else if (timer_q == STEP_T) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RAIL_ON;
        end
      end

      ST_RST_DLY: begin
        if (!i_PwrOnReq) begin
          state_d          = ST_RAIL_OFF;
          rail_en_d[idx_q] = 1'b0;
          plt_rst_n_d      = 1'b0;
        end else if (timer_q == RST_T) begin
          state_d     = ST_RUN;
          plt_rst_n_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (enabled_lost) begin
          state_d     = ST_FAULT;
          rail_en_d   = '0;
          plt_rst_n_d = 1'b0;
          pwr_fault_d = 1'b1;
        end else if (!i_PwrOnReq) begin
          state_d          = ST_RAIL_OFF;
          rail_en_d[idx_q] = 1'b0;
          plt_rst_n_d      = 1'b0;
        end
      end

      // Shutdown always completes; the timer restarts after each rail drops.
      ST_RAIL_OFF: begin
        plt_rst_n_d = 1'b0;
        if (timer_q == STEP_T) begin
          if (idx_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            idx_d              = idx_dec;
            rail_en_d[idx_dec] = 1'b0;
            step_restart       = 1'b1;
          end
        end
      end

      ST_FAULT: begin
        rail_en_d   = '0;
        plt_rst_n_d = 1'b0;
        if (!i_PwrOnReq) begin
          state_d     = ST_IDLE;
          pwr_fault_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    timer_d = (state_d != state_q || step_restart) ? 8'd0 : timer_next(timer_q);
  end

  always_ff @(posedge i_InitialSoc or negedge i_SbyReset_n) begin
    if (!i_SbyReset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= 8'd0;
      idx_q       <= '0;
      rail_en_q   <= '0;
      plt_rst_n_q <= 1'b0;
      pwr_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      rail_en_q   <= rail_en_d;
      plt_rst_n_q <= plt_rst_n_d;
      pwr_fault_q <= pwr_fault_d;
    end
  end

  assign o_RailEn   = rail_en_q;
  assign o_PltRst_n = plt_rst_n_q;
  assign o_PwrFault = pwr_fault_q;
  assign o_SeqState = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Randomized bench for pwr_seq_ctrl: a rail plant raises power-good after a
// random delay and the expected edge of every event is computed arithmetically.
module tb_pwr_seq_ctrl;

  localparam int RAILS  = 4;
  localparam int P_TO   = 15;
  localparam int P_STEP = 3;
  localparam int P_RST  = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwr_on;
  logic [RAILS-1:0] rail_pg;
  logic [RAILS-1:0] rail_en;
  logic             plt_rst_n;
  logic             pwr_fault;
  logic [2:0]       seq_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pg_delay [RAILS];
  bit force_low[RAILS];
  int en_age   [RAILS];
  int w_edge   [RAILS];

  always #5 clk = ~clk;

  pwr_seq_ctrl #(
    .RAIL_NUM  (RAILS),
    .PG_TIMEOUT(P_TO),
    .STEP_DLY  (P_STEP),
    .RST_DLY   (P_RST)
  ) dut (
    .i_InitialSoc(clk),
    .i_SbyReset_n(rst_n),
    .i_PwrOnReq  (pwr_on),
    .i_RailPG    (rail_pg),
    .o_RailEn    (rail_en),
    .o_PltRst_n  (plt_rst_n),
    .o_PwrFault  (pwr_fault),
    .o_SeqState  (seq_state)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // One clock edge; afterwards cyc is the number of the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < RAILS; i++) begin
      if (rail_en[i]) en_age[i]++;
      else en_age[i] = 0;
      rail_pg[i] = rail_en[i] && !force_low[i] && (en_age[i] > pg_delay[i]);
    end
  endtask

  task automatic draw_delays();
    for (int i = 0; i < RAILS; i++) begin
      pg_delay[i]  = int'($urandom_range(1, P_TO - 3));
      force_low[i] = 1'b0;
    end
  endtask

  // Edge at which each rail enable rises, given power-on driven after edge 'start'.
  task automatic plan_edges(input int start);
    w_edge[0] = start + 2;
    for (int i = 1; i < RAILS; i++)
      w_edge[i] = w_edge[i-1] + pg_delay[i-1] + 3 + P_STEP + 2;
  endtask

  task automatic bring_up();
    int run_edge;
    logic [RAILS-1:0] exp_en;
    logic exp_rst;
    draw_delays();
    plan_edges(cyc);
    pwr_on = 1'b1;
    run_edge = w_edge[RAILS-1] + pg_delay[RAILS-1] + 3 + P_RST + 1;
    while (cyc < run_edge) begin
      tick();
      exp_en = '0;
      for (int i = 0; i < RAILS; i++) if (cyc >= w_edge[i]) exp_en[i] = 1'b1;
      exp_rst = (cyc >= run_edge);
      checks++;
      if (rail_en !== exp_en || plt_rst_n !== exp_rst) begin
        errors++;
        $display("[TB] FAIL up_seq cyc=%0d rail_en=%b expected %b plt_rst_n=%b expected %b",
                 cyc, rail_en, exp_en, plt_rst_n, exp_rst);
      end
      for (int i = 0; i < RAILS; i++) begin
        if (cyc == w_edge[i]) begin
          checks++;
          if (seq_state !== 3'd2) begin
            errors++;
            $display("[TB] FAIL up_wait_pg rail=%0d state=%0d expected 2", i, seq_state);
          end
        end
      end
    end
    checks++;
    if (seq_state !== 3'd5 || pwr_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_run state=%0d expected 5 fault=%b expected 0", seq_state, pwr_fault);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pwr_on = 1'b1;
    rail_pg = '0;
    for (int i = 0; i < RAILS; i++) begin
      force_low[i] = 1'b0;
      pg_delay[i]  = 1;
      en_age[i]    = 0;
    end
    repeat (3) tick();
    checks++;
    if (rail_en !== '0 || plt_rst_n !== 1'b0 || pwr_fault !== 1'b0 || seq_state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_values en=%b rst_n=%b fault=%b state=%0d expected 0000/0/0/0",
               rail_en, plt_rst_n, pwr_fault, seq_state);
    end
    pwr_on = 1'b0;
    rst_n  = 1'b1;
    tick();
    checks++;
    if (seq_state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle state=%0d expected 0", seq_state);
    end
  endtask

  task automatic test_orderly_off(input bit reassert);
    int p;
    int idle_edge;
    logic [RAILS-1:0] exp_en;
    p = cyc;
    pwr_on = 1'b0;
    idle_edge = p + 1 + (P_STEP + 1) * RAILS;
    while (cyc < idle_edge + 1) begin
      tick();
      if (reassert && cyc == p + 5) pwr_on = 1'b1;
      if (cyc == idle_edge - 1) pwr_on = 1'b0;
      for (int k = 0; k < RAILS; k++)
        exp_en[k] = (cyc < p + 1 + (P_STEP + 1) * (RAILS - 1 - k));
      checks++;
      if (rail_en !== exp_en || plt_rst_n !== 1'b0) begin
        errors++;
        $display("[TB] FAIL off_seq cyc=%0d rail_en=%b expected %b plt_rst_n=%b expected 0",
                 cyc, rail_en, exp_en, plt_rst_n);
      end
      if (cyc == idle_edge - 1) begin
        checks++;
        if (seq_state !== 3'd6) begin
          errors++;
          $display("[TB] FAIL off_state state=%0d expected 6", seq_state);
        end
      end
      if (cyc >= idle_edge) begin
        checks++;
        if (seq_state !== 3'd0) begin
          errors++;
          $display("[TB] FAIL off_idle cyc=%0d state=%0d expected 0", cyc, seq_state);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int r;
    int fault_edge;
    logic [RAILS-1:0] exp_en;
    draw_delays();
    r = int'($urandom_range(0, RAILS - 1));
    force_low[r] = 1'b1;
    plan_edges(cyc);
    pwr_on = 1'b1;
    fault_edge = w_edge[r] + P_TO + 1;
    exp_en = '0;
    for (int i = 0; i <= r; i++) exp_en[i] = 1'b1;
    while (cyc < fault_edge) begin
      tick();
      if (cyc == fault_edge - 1) begin
        checks++;
        if (seq_state !== 3'd2 || rail_en !== exp_en) begin
          errors++;
          $display("[TB] FAIL timeout_wait rail=%0d state=%0d expected 2 en=%b expected %b",
                   r, seq_state, rail_en, exp_en);
        end
      end
    end
    checks++;
    if (seq_state !== 3'd7 || rail_en !== '0 || pwr_fault !== 1'b1 || plt_rst_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_fault state=%0d expected 7 en=%b expected 0000 fault=%b expected 1",
               seq_state, rail_en, pwr_fault);
    end
    pwr_on = 1'b0;
    tick();
    checks++;
    if (seq_state !== 3'd0 || pwr_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear state=%0d expected 0 fault=%b expected 0", seq_state, pwr_fault);
    end
    force_low[r] = 1'b0;
  endtask

  task automatic test_runtime_loss();
    int r;
    bring_up();
    r = int'($urandom_range(0, RAILS - 1));
    force_low[r] = 1'b1;
    rail_pg[r]   = 1'b0;
    tick();
    tick();
    checks++;
    if (seq_state !== 3'd5) begin
      errors++;
      $display("[TB] FAIL loss_sync_lag state=%0d expected 5", seq_state);
    end
    tick();
    checks++;
    if (seq_state !== 3'd7 || plt_rst_n !== 1'b0 || rail_en !== '0 || pwr_fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loss_fault rail=%0d state=%0d expected 7 rst_n=%b en=%b fault=%b",
               r, seq_state, plt_rst_n, rail_en, pwr_fault);
    end
    pwr_on = 1'b0;
    tick();
    checks++;
    if (seq_state !== 3'd0 || pwr_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loss_clear state=%0d expected 0 fault=%b expected 0", seq_state, pwr_fault);
    end
    force_low[r] = 1'b0;
  endtask

  task automatic test_simultaneous();
    int r;
    bring_up();
    r = int'($urandom_range(0, RAILS - 1));
    force_low[r] = 1'b1;
    rail_pg[r]   = 1'b0;
    tick();
    tick();
    checks++;
    if (seq_state !== 3'd5) begin
      errors++;
      $display("[TB] FAIL simul_pre state=%0d expected 5", seq_state);
    end
    pwr_on = 1'b0;
    tick();
    checks++;
    if (seq_state !== 3'd7 || pwr_fault !== 1'b1 || rail_en !== '0) begin
      errors++;
      $display("[TB] FAIL simul_priority state=%0d expected 7 fault=%b expected 1 en=%b",
               seq_state, pwr_fault, rail_en);
    end
    tick();
    checks++;
    if (seq_state !== 3'd0 || pwr_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_clear state=%0d expected 0 fault=%b expected 0", seq_state, pwr_fault);
    end
    force_low[r] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int target;
    draw_delays();
    plan_edges(cyc);
    pwr_on = 1'b1;
    target = w_edge[0] + pg_delay[0] + 3 + 1;
    while (cyc < target) tick();
    checks++;
    if (seq_state !== 3'd3 || rail_en !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL mid_step state=%0d expected 3 en=%b expected 0001", seq_state, rail_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rail_en !== '0 || plt_rst_n !== 1'b0 || pwr_fault !== 1'b0 || seq_state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL mid_async en=%b rst_n=%b fault=%b state=%0d expected 0000/0/0/0",
               rail_en, plt_rst_n, pwr_fault, seq_state);
    end
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (seq_state !== 3'd1 || rail_en !== '0) begin
      errors++;
      $display("[TB] FAIL mid_resume state=%0d expected 1 en=%b expected 0000", seq_state, rail_en);
    end
    pwr_on = 1'b0;
    repeat (30) tick();
    checks++;
    if (seq_state !== 3'd0 || rail_en !== '0) begin
      errors++;
      $display("[TB] FAIL mid_settle state=%0d expected 0 en=%b expected 0000", seq_state, rail_en);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      bring_up();
      test_orderly_off(bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    $display("[TB] pwr_seq_ctrl bench start");
    test_reset();
    bring_up();
    test_orderly_off(1'b0);
    test_timeout();
    test_runtime_loss();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
